// File: rtl/fixed_point_differentiator.sv
// fixed_point_differentiator
// Streaming first-difference stage: y[n] = x[n] - x[n-1], signed fixed point,
// saturating. Valid/ready on both sides with one registered result slot, so a
// sample accepted at one edge presents its result right after that edge.
module fixed_point_differentiator #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sat,
  output logic             sat_seen
);

  // The difference needs one guard bit above the sample: integer bits,
  // fraction bits, plus one. The binary point itself does not affect the math.
  localparam int IntBits = WIDTH - FRAC;
  localparam int DW      = IntBits + FRAC + 1;

  typedef enum logic {
    EMPTY  = 1'b0,
    PRIMED = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_prev_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_sat_q;
  logic             sat_seen_q;

  logic             accept_d;
  logic [DW-1:0]    diff_d;
  logic             sat_hi_d;
  logic             sat_lo_d;
  logic [WIDTH-1:0] result_d;

  // Handshake, widened subtraction and clipping of the difference.
  always_comb begin
    in_ready = !clear && (!out_valid_q || out_ready);
    accept_d = in_valid && in_ready;
    diff_d   = {in_data[WIDTH-1], in_data} - {x_prev_q[WIDTH-1], x_prev_q};
    // Guard bit disagreeing with the top sample bit means the result left range.
    sat_hi_d = !diff_d[DW-1] &&  diff_d[WIDTH-1];
    sat_lo_d =  diff_d[DW-1] && !diff_d[WIDTH-1];
    result_d = diff_d[WIDTH-1:0];
    if (sat_hi_d) begin
      result_d = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (sat_lo_d) begin
      result_d = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end

  // Priming FSM, sample history and the registered result slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= EMPTY;
      x_prev_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_seen_q  <= 1'b0;
    end else if (clear) begin
      // Flush history and drop any pending result; the offered sample is not taken.
      state_q     <= EMPTY;
      x_prev_q    <= '0;
      out_valid_q <= 1'b0;
      sat_seen_q  <= 1'b0;
    end else if (accept_d) begin
      x_prev_q <= in_data;
      case (state_q)
        EMPTY: begin
          // First sample only seeds the history; an old result may retire here.
          state_q     <= PRIMED;
          out_valid_q <= 1'b0;
        end
        default: begin
          out_valid_q <= 1'b1;
          out_data_q  <= result_d;
          out_sat_q   <= sat_hi_d || sat_lo_d;
          if (sat_hi_d || sat_lo_d) begin
            sat_seen_q <= 1'b1;
          end
        end
      endcase
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_seen  = sat_seen_q;

endmodule
